decode_sequencer: RTL and testbench
===================================

Name: decode_sequencer

Overview:
- Parametrised multi-cycle sequencer for the decode stage. It replaces the fixed two-iteration call and interrupt controllers.
- Expands CALL, RET, INT and RTI into a run of stack micro-iterations, one word per cycle, followed by a fetch flush.
- Sized for any PC width and data-word width.
- Sits beside the control unit. Decode ORs its push/pop/stall/flush outputs into the ID/EX control bundle.

Parameters:
- DATA_W, 16, stack/memory word width in bits.
- PC_W, 32, PC width in bits. Must be a multiple of DATA_W.
- FLUSH_CYCLES, 1, number of cycles flush is held after the last iteration (1..3).
- Derived localparams: PC_WORDS = PC_W/DATA_W. CNT_W = $clog2(PC_WORDS+2).

Ports:
- Clk  input  1  clock, rising edge
- Rst  input  1  synchronous, active-high reset
- call_req  input  1  decoded CALL in decode this cycle
- ret_req  input  1  decoded RET in decode this cycle
- rti_req  input  1  decoded RTI in decode this cycle
- int_req  input  1  interrupt pin as pipelined from fetch (level, sampled each cycle)
- hold  input  1  downstream hazard stall; freezes the sequencer
- stall_fetch  output  1  freeze PC and IF/ID register
- push  output  1  this cycle is a stack-write iteration
- pop  output  1  this cycle is a stack-read iteration
- word_idx  output  CNT_W  index of the word being moved (0 = least-significant PC word; PC_WORDS = flags word)
- last_word  output  1  final iteration of the current sequence
- flush  output  1  squash IF/ID contents
- seq_kind  output  2  00 CALL, 01 RET, 10 INT, 11 RTI; valid while busy
- busy  output  1  sequence in progress (state != IDLE)
- int_pending  output  1  interrupt latched, awaiting service

Behaviour:
- Reset: on a Clk edge with Rst=1, all registers clear. State goes to IDLE, counter to 0, int_pending to 0. All outputs read 0. Reset mid-sequence aborts it immediately; no partial-iteration output on the next cycle.
- States:
  - IDLE: no sequence active.
  - ITER: micro-iterations in progress.
  - FLUSH: fetch flush in progress.
- Acceptance in IDLE, by priority:
  1. int_pending or int_req → INT
  2. call_req → CALL
  3. ret_req → RET
  4. rti_req → RTI
  - In the accept cycle: stall_fetch=1 combinationally. No push or pop. At the edge, seq_kind is captured, counter=0, and state → ITER.
  - If INT wins while an instruction request is also present, the instruction is not lost. Fetch is stalled, so the request re-presents after the sequence completes.
- Iteration counts: CALL pushes PC_WORDS words. INT pushes PC_WORDS+1 (PC words, then flags). RET pops PC_WORDS. RTI pops PC_WORDS+1 (flags first, then PC words from most-significant to least).
  - CALL/INT word order: word_idx = counter.
  - RTI word order: word_idx = PC_WORDS − counter.
  - RET word order: word_idx = PC_WORDS−1 − counter.
- ITER outputs: stall_fetch=1, busy=1. push=1 for CALL/INT, pop=1 for RET/RTI. last_word=1 when counter = count−1.
  - Edge: counter increments. After the last word, state → FLUSH and the flush counter loads 0.
- FLUSH outputs: flush=1, stall_fetch=1, busy=1. Holds for FLUSH_CYCLES cycles, then state → IDLE.
  - stall_fetch drops in the first IDLE cycle unless a new accept happens that cycle.
- hold=1: state, counters and seq_kind are frozen. push, pop and flush are forced to 0. stall_fetch and busy keep their values. An accept in IDLE is deferred.
- Interrupts:
  - int_req seen while busy or hold sets int_pending.
  - int_pending clears on the edge that accepts the INT sequence.
  - int_req during an INT sequence re-sets it, allowing a back-to-back INT.
- Requests arriving in ITER or FLUSH are ignored (the fetch stall guarantees re-presentation).

Decomposition:
- Shared package decode_pkg:
  - seq_kind encodings SEQ_CALL/SEQ_RET/SEQ_INT/SEQ_RTI.
  - State encodings ST_IDLE/ST_ITER/ST_FLUSH.
  - Default DATA_W/PC_W.
- One sub-module: seq_counter, a loadable up-counter with enable, terminal-count compare and hold. It is instantiated twice, for iterations and for flush.

Test Plan:
Defaults unless noted (PC_WORDS=2).
- Reset then call_req pulse at T → stall_fetch at T. push at T+1,T+2 with word_idx 0,1. last_word at T+2. flush at T+3. busy=0 and stall_fetch=0 at T+4.
- rti_req at T → pop at T+1..T+3 with word_idx 2,1,0. seq_kind=11. flush at T+4.
- int_req and call_req together at T → seq_kind=10. Three pushes (idx 0,1,2). After idle, the held call_req is accepted at T+5.
- int_req pulse during a RET at T+1 → int_pending=1 from T+2. INT accepted at the first IDLE cycle. int_pending clears on that edge.
- hold=1 at the second CALL iteration for 3 cycles → push=0 and word_idx frozen at 1 during hold. Sequence completes 3 cycles late with the same word order.
- Rst=1 during ITER → next cycle all outputs 0. Rerun with PC_W=48, DATA_W=16, FLUSH_CYCLES=2 → CALL gives 3 pushes and 2 flush cycles.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared encodings and defaults for the decode-stage call/interrupt sequencer.
package decode_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_PC_W   = 32;

    // Kind of stack sequence being expanded
    typedef enum logic [1:0] {
        SEQ_CALL = 2'b00,
        SEQ_RET  = 2'b01,
        SEQ_INT  = 2'b10,
        SEQ_RTI  = 2'b11
    } seq_kind_e;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ITER  = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    // CALL and INT write the stack; RET and RTI read it back
    function automatic logic is_push_kind(input seq_kind_e kind);
        return (kind == SEQ_CALL) || (kind == SEQ_INT);
    endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable up-counter with enable, freeze input and terminal-count compare.
module seq_counter #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic         hold_i,
    input  logic [W-1:0] tc_value_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_d, count_q;

    // Next count: freeze wins, then load-to-zero, then increment
    always_comb begin
        // NOTE: every combinational output is given a default first so no path leaves it unassigned (which would infer a latch).
        count_d = count_q;
        if (!hold_i) begin
            if (load_i) begin
                count_d = '0;
            end else if (en_i) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == tc_value_i);

endmodule

// File: rtl/decode_sequencer.sv
// Expands CALL/RET/INT/RTI into per-word stack iterations followed by a fetch flush.
module decode_sequencer
    import decode_pkg::*;
#(
    parameter  int DATA_W       = DEF_DATA_W,
    parameter  int PC_W         = DEF_PC_W,
    parameter  int FLUSH_CYCLES = 1,
    localparam int PC_WORDS     = PC_W / DATA_W,
    localparam int CNT_W        = $clog2(PC_WORDS + 2)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             call_req,
    input  logic             ret_req,
    input  logic             rti_req,
    input  logic             int_req,
    input  logic             hold,
    output logic             stall_fetch,
    output logic             push,
    output logic             pop,
    output logic [CNT_W-1:0] word_idx,
    output logic             last_word,
    output logic             flush,
    output logic [1:0]       seq_kind,
    output logic             busy,
    output logic             int_pending
);

    localparam int               FL_W  = 2;
    localparam logic [CNT_W-1:0] PCW_C = CNT_W'(PC_WORDS);

    state_e            state_d, state_q;
    seq_kind_e         kind_d, kind_q, kind_sel;
    logic              int_pending_d, int_pending_q;
    logic              any_req, accept;
    logic              iter_load, iter_en, iter_tc;
    logic              flush_load, flush_en, flush_tc;
    logic [CNT_W-1:0]  iter_cnt, iter_tc_val;
    logic [FL_W-1:0]   flush_cnt;

    // Request arbitration in IDLE: interrupt, then CALL, RET, RTI
    always_comb begin
        kind_sel = SEQ_CALL;
        any_req  = 1'b0;
        if (int_pending_q || int_req) begin
            kind_sel = SEQ_INT;
            any_req  = 1'b1;
        end else if (call_req) begin
            kind_sel = SEQ_CALL;
            any_req  = 1'b1;
        end else if (ret_req) begin
            kind_sel = SEQ_RET;
            any_req  = 1'b1;
        end else if (rti_req) begin
            kind_sel = SEQ_RTI;
            any_req  = 1'b1;
        end
        accept = (state_q == ST_IDLE) && any_req && !hold && !Rst;
    end

    // Next state, captured kind and counter controls; hold freezes everything
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        iter_load  = 1'b0;
        iter_en    = 1'b0;
        flush_load = 1'b0;
        flush_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_ITER;
                    kind_d    = kind_sel;
                    iter_load = 1'b1;
                end
            end
            ST_ITER: begin
                iter_en = 1'b1;
                if (iter_tc) begin
                    state_d    = ST_FLUSH;
                    flush_load = 1'b1;
                end
            end
            ST_FLUSH: begin
                flush_en = 1'b1;
                if (flush_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (hold) begin
            state_d = state_q;
            kind_d  = kind_q;
        end
    end

    // Interrupt latch: cleared when INT is accepted, set by any interrupt not taken at once
    always_comb begin
        int_pending_d = int_pending_q;
        if (accept && (kind_sel == SEQ_INT)) begin
            int_pending_d = 1'b0;
        end else if (int_req && (busy || hold)) begin
            int_pending_d = 1'b1;
        end
    end

    // Output decode from state and captured sequence kind
    always_comb begin
        busy        = (state_q != ST_IDLE);
        stall_fetch = busy || accept;
        push        = (state_q == ST_ITER) && !hold && is_push_kind(kind_q);
        pop         = (state_q == ST_ITER) && !hold && !is_push_kind(kind_q);
        last_word   = (state_q == ST_ITER) && iter_tc;
        flush       = (state_q == ST_FLUSH) && !hold;
        seq_kind    = busy ? kind_q : SEQ_CALL;
        iter_tc_val = ((kind_q == SEQ_INT) || (kind_q == SEQ_RTI)) ? PCW_C : PCW_C - 1'b1;
        word_idx    = '0;
        if (state_q == ST_ITER) begin
            case (kind_q)
                SEQ_RTI: word_idx = PCW_C - iter_cnt;
                SEQ_RET: word_idx = PCW_C - 1'b1 - iter_cnt;
                default: word_idx = iter_cnt;
            endcase
        end
    end

    // State, kind and interrupt-latch registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= ST_IDLE;
            kind_q        <= SEQ_CALL;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            int_pending_q <= int_pending_d;
        end
    end

    assign int_pending = int_pending_q;

    seq_counter #(.W(CNT_W)) u_iter_cnt (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .load_i     (iter_load),
        .en_i       (iter_en),
        .hold_i     (hold),
        .tc_value_i (iter_tc_val),
        .count_o    (iter_cnt),
        .tc_o       (iter_tc)
    );

    seq_counter #(.W(FL_W)) u_flush_cnt (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .load_i     (flush_load),
        .en_i       (flush_en),
        .hold_i     (hold),
        .tc_value_i (FL_W'(FLUSH_CYCLES - 1)),
        .count_o    (flush_cnt),
        .tc_o       (flush_tc)
    );

    // The flush counter never runs past its terminal value while flushing
    a_flush_range: assert property (@(posedge Clk) disable iff (Rst)
        (state_q == ST_FLUSH) |-> (flush_cnt < FL_W'(FLUSH_CYCLES)));

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer: default 32/16 instance plus a 48/16, 2-flush instance.
module tb_decode_sequencer;

    logic       Clk;
    logic       Rst;
    logic       call_req, ret_req, rti_req, int_req, hold;
    logic       a_stall, a_push, a_pop, a_last, a_flush, a_busy, a_pend;
    logic [1:0] a_idx;
    logic [1:0] a_kind;

    logic       b_call;
    logic       b_stall, b_push, b_pop, b_last, b_flush, b_busy, b_pend;
    logic [2:0] b_idx;
    logic [1:0] b_kind;

    int pass_cnt  = 0;
    int total_cnt = 0;

    decode_sequencer dut_a (
        .Clk         (Clk),
        .Rst         (Rst),
        .call_req    (call_req),
        .ret_req     (ret_req),
        .rti_req     (rti_req),
        .int_req     (int_req),
        .hold        (hold),
        .stall_fetch (a_stall),
        .push        (a_push),
        .pop         (a_pop),
        .word_idx    (a_idx),
        .last_word   (a_last),
        .flush       (a_flush),
        .seq_kind    (a_kind),
        .busy        (a_busy),
        .int_pending (a_pend)
    );

    decode_sequencer #(.DATA_W(16), .PC_W(48), .FLUSH_CYCLES(2)) dut_b (
        .Clk         (Clk),
        .Rst         (Rst),
        .call_req    (b_call),
        .ret_req     (1'b0),
        .rti_req     (1'b0),
        .int_req     (1'b0),
        .hold        (1'b0),
        .stall_fetch (b_stall),
        .push        (b_push),
        .pop         (b_pop),
        .word_idx    (b_idx),
        .last_word   (b_last),
        .flush       (b_flush),
        .seq_kind    (b_kind),
        .busy        (b_busy),
        .int_pending (b_pend)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Observation vector A: {stall, push, pop, idx[1:0], last, flush, kind[1:0], busy, pend}
    function automatic logic [10:0] obs_a();
        return {a_stall, a_push, a_pop, a_idx, a_last, a_flush, a_kind, a_busy, a_pend};
    endfunction

    // Observation vector B: {stall, push, pop, idx[2:0], last, flush, busy}
    function automatic logic [8:0] obs_b();
        return {b_stall, b_push, b_pop, b_idx, b_last, b_flush, b_busy};
    endfunction

    // Stimulus vector: {Rst, int_req, call_req, ret_req, rti_req, hold}
    task automatic drive(input logic [5:0] s);
        {Rst, int_req, call_req, ret_req, rti_req, hold} = s;
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] oa;
        logic [8:0]  ob;
        drive(6'b100000);
        b_call = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        oa = obs_a();
        ob = obs_b();
        total_cnt++;
        if (oa !== 11'b0) $display("FAIL reset_a_in_rst: got %b expected %b", oa, 11'b0);
        else pass_cnt++;
        total_cnt++;
        if (ob !== 9'b0) $display("FAIL reset_b_in_rst: got %b expected %b", ob, 9'b0);
        else pass_cnt++;
        drive(6'b000000);
        next_cycle();
        #1;
        oa = obs_a();
        ob = obs_b();
        total_cnt++;
        if (oa !== 11'b0) $display("FAIL reset_a_idle: got %b expected %b", oa, 11'b0);
        else pass_cnt++;
        total_cnt++;
        if (ob !== 9'b0) $display("FAIL reset_b_idle: got %b expected %b", ob, 9'b0);
        else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_call();
        logic [5:0]  stim  [0:4];
        logic [10:0] exp_v [0:4];
        logic [10:0] oa;
        stim  = '{6'b001000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
        exp_v = '{11'b1_0_0_00_0_0_00_0_0,
                  11'b1_1_0_00_0_0_00_1_0,
                  11'b1_1_0_01_1_0_00_1_0,
                  11'b1_0_0_00_0_1_00_1_0,
                  11'b0_0_0_00_0_0_00_0_0};
        for (int i = 0; i < 5; i++) begin
            drive(stim[i]);
            #1;
            oa = obs_a();
            total_cnt++;
            if (oa !== exp_v[i]) $display("FAIL call[%0d]: got %b expected %b", i, oa, exp_v[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    task automatic test_rti();
        logic [5:0]  stim  [0:5];
        logic [10:0] exp_v [0:5];
        logic [10:0] oa;
        stim  = '{6'b000010, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
        exp_v = '{11'b1_0_0_00_0_0_00_0_0,
                  11'b1_0_1_10_0_0_11_1_0,
                  11'b1_0_1_01_0_0_11_1_0,
                  11'b1_0_1_00_1_0_11_1_0,
                  11'b1_0_0_00_0_1_11_1_0,
                  11'b0_0_0_00_0_0_00_0_0};
        for (int i = 0; i < 6; i++) begin
            drive(stim[i]);
            #1;
            oa = obs_a();
            total_cnt++;
            if (oa !== exp_v[i]) $display("FAIL rti[%0d]: got %b expected %b", i, oa, exp_v[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    // INT beats a simultaneous CALL; the CALL stays asserted and is taken afterwards
    task automatic test_int_over_call();
        logic [5:0]  stim  [0:9];
        logic [10:0] exp_v [0:9];
        logic [10:0] oa;
        stim  = '{6'b011000, 6'b001000, 6'b001000, 6'b001000, 6'b001000,
                  6'b001000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
        exp_v = '{11'b1_0_0_00_0_0_00_0_0,
                  11'b1_1_0_00_0_0_10_1_0,
                  11'b1_1_0_01_0_0_10_1_0,
                  11'b1_1_0_10_1_0_10_1_0,
                  11'b1_0_0_00_0_1_10_1_0,
                  11'b1_0_0_00_0_0_00_0_0,
                  11'b1_1_0_00_0_0_00_1_0,
                  11'b1_1_0_01_1_0_00_1_0,
                  11'b1_0_0_00_0_1_00_1_0,
                  11'b0_0_0_00_0_0_00_0_0};
        for (int i = 0; i < 10; i++) begin
            drive(stim[i]);
            #1;
            oa = obs_a();
            total_cnt++;
            if (oa !== exp_v[i]) $display("FAIL int_call[%0d]: got %b expected %b", i, oa, exp_v[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    // Interrupt pulse during RET latches and is serviced at the first IDLE cycle
    task automatic test_int_during_ret();
        logic [5:0]  stim  [0:9];
        logic [10:0] exp_v [0:9];
        logic [10:0] oa;
        stim  = '{6'b000100, 6'b010000, 6'b000000, 6'b000000, 6'b000000,
                  6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
        exp_v = '{11'b1_0_0_00_0_0_00_0_0,
                  11'b1_0_1_01_0_0_01_1_0,
                  11'b1_0_1_00_1_0_01_1_1,
                  11'b1_0_0_00_0_1_01_1_1,
                  11'b1_0_0_00_0_0_00_0_1,
                  11'b1_1_0_00_0_0_10_1_0,
                  11'b1_1_0_01_0_0_10_1_0,
                  11'b1_1_0_10_1_0_10_1_0,
                  11'b1_0_0_00_0_1_10_1_0,
                  11'b0_0_0_00_0_0_00_0_0};
        for (int i = 0; i < 10; i++) begin
            drive(stim[i]);
            #1;
            oa = obs_a();
            total_cnt++;
            if (oa !== exp_v[i]) $display("FAIL int_ret[%0d]: got %b expected %b", i, oa, exp_v[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    // Three hold cycles on the second CALL word stretch the sequence by three cycles
    task automatic test_hold_iter();
        logic [5:0]  stim  [0:7];
        logic [10:0] exp_v [0:7];
        logic [10:0] oa;
        stim  = '{6'b001000, 6'b000000, 6'b000001, 6'b000001,
                  6'b000001, 6'b000000, 6'b000000, 6'b000000};
        exp_v = '{11'b1_0_0_00_0_0_00_0_0,
                  11'b1_1_0_00_0_0_00_1_0,
                  11'b1_0_0_01_1_0_00_1_0,
                  11'b1_0_0_01_1_0_00_1_0,
                  11'b1_0_0_01_1_0_00_1_0,
                  11'b1_1_0_01_1_0_00_1_0,
                  11'b1_0_0_00_0_1_00_1_0,
                  11'b0_0_0_00_0_0_00_0_0};
        for (int i = 0; i < 8; i++) begin
            drive(stim[i]);
            #1;
            oa = obs_a();
            total_cnt++;
            if (oa !== exp_v[i]) $display("FAIL hold_iter[%0d]: got %b expected %b", i, oa, exp_v[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    // Interrupt under hold in IDLE is deferred via int_pending
    task automatic test_hold_idle();
        logic [5:0]  stim  [0:6];
        logic [10:0] exp_v [0:6];
        logic [10:0] oa;
        stim  = '{6'b010001, 6'b000000, 6'b000000, 6'b000000,
                  6'b000000, 6'b000000, 6'b000000};
        exp_v = '{11'b0_0_0_00_0_0_00_0_0,
                  11'b1_0_0_00_0_0_00_0_1,
                  11'b1_1_0_00_0_0_10_1_0,
                  11'b1_1_0_01_0_0_10_1_0,
                  11'b1_1_0_10_1_0_10_1_0,
                  11'b1_0_0_00_0_1_10_1_0,
                  11'b0_0_0_00_0_0_00_0_0};
        for (int i = 0; i < 7; i++) begin
            drive(stim[i]);
            #1;
            oa = obs_a();
            total_cnt++;
            if (oa !== exp_v[i]) $display("FAIL hold_idle[%0d]: got %b expected %b", i, oa, exp_v[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    // Reset asserted during the first CALL iteration aborts the sequence cleanly
    task automatic test_reset_mid();
        logic [5:0]  stim  [0:3];
        logic [10:0] exp_v [0:3];
        logic [10:0] oa;
        stim  = '{6'b001000, 6'b100000, 6'b000000, 6'b000000};
        exp_v = '{11'b1_0_0_00_0_0_00_0_0,
                  11'b1_1_0_00_0_0_00_1_0,
                  11'b0_0_0_00_0_0_00_0_0,
                  11'b0_0_0_00_0_0_00_0_0};
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            #1;
            oa = obs_a();
            total_cnt++;
            if (oa !== exp_v[i]) $display("FAIL reset_mid[%0d]: got %b expected %b", i, oa, exp_v[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    // 48-bit PC over 16-bit words with two flush cycles
    task automatic test_wide_call();
        logic       stim  [0:6];
        logic [8:0] exp_v [0:6];
        logic [8:0] ob;
        stim  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_v = '{9'b1_0_0_000_0_0_0,
                  9'b1_1_0_000_0_0_1,
                  9'b1_1_0_001_0_0_1,
                  9'b1_1_0_010_1_0_1,
                  9'b1_0_0_000_0_1_1,
                  9'b1_0_0_000_0_1_1,
                  9'b0_0_0_000_0_0_0};
        for (int i = 0; i < 7; i++) begin
            b_call = stim[i];
            #1;
            ob = obs_b();
            total_cnt++;
            if (ob !== exp_v[i]) $display("FAIL wide_call[%0d]: got %b expected %b", i, ob, exp_v[i]);
            else pass_cnt++;
            next_cycle();
        end
    endtask

    initial begin
        drive(6'b100000);
        b_call = 1'b0;
        test_reset();
        test_call();
        test_rti();
        test_int_over_call();
        test_int_during_ret();
        test_hold_iter();
        test_hold_idle();
        test_reset_mid();
        test_wide_call();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
